// File: rtl/shadow_dcache_port_arbiter_pkg.sv
// Shared types for the shadow D$ store-port arbiter.
//
// Contents:
//   dc_port_owner_e     - which requester currently holds the D$ store port
//   SHRU_DEFAULT_BURST  - default number of back-to-back SHRU grants while LSU waits
//   dcache_store_req_t  - D$ store request (requester -> cache)
//   dcache_store_rsp_t  - D$ store response (cache -> requester)
//
// The widths below describe the store port of a 32-bit core with a
// 32-bit physical address split into a 12-bit index and a 20-bit tag.
package shadow_dcache_port_arbiter_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 20;
  localparam int unsigned SHRU_DEFAULT_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_SHRU = 2'd2
  } dc_port_owner_e;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_store_req_t;

  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
  } dcache_store_rsp_t;

endpackage

// File: rtl/shadow_dcache_port_arbiter.sv
// Shares one D$ store request port between the LSU store unit and the
// shadow-register save engine (SHRU).
//
// SHRU wins simultaneous requests so interrupt context saves drain quickly.
// A burst counter limits how many SHRU grants may pass an LSU that is
// waiting; once it saturates the LSU is served next. Once a requester has
// been presented to the cache without a grant it keeps the port (sticky
// ownership) until it is granted or withdraws its request.
//
// Ports:
//   clk_i          in   clock
//   rst_ni         in   synchronous active-low reset
//   lsu_req_i      in   LSU store request
//   lsu_rsp_o      out  response to LSU (gnt, and all read data from the cache)
//   shru_req_i     in   shadow save request
//   shru_rsp_o     out  response to SHRU (gnt only, never rvalid)
//   dcache_req_o   out  request forwarded to the D$
//   dcache_rsp_i   in   response from the D$
//   shru_owner_o   out  SHRU is the selected requester this cycle
//   lsu_starved_o  out  LSU is waiting and the burst counter is saturated
module shadow_dcache_port_arbiter
  import shadow_dcache_port_arbiter_pkg::*;
#(
  parameter type         dcache_req_i_t = dcache_store_req_t,
  parameter type         dcache_req_o_t = dcache_store_rsp_t,
  parameter int unsigned MAX_SHRU_BURST = SHRU_DEFAULT_BURST
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t lsu_req_i,
  output dcache_req_o_t lsu_rsp_o,
  input  dcache_req_i_t shru_req_i,
  output dcache_req_o_t shru_rsp_o,
  output dcache_req_i_t dcache_req_o,
  input  dcache_req_o_t dcache_rsp_i,
  output logic          shru_owner_o,
  output logic          lsu_starved_o
);

  localparam int unsigned        BURST_W   = $clog2(MAX_SHRU_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_SHRU_BURST);

  dc_port_owner_e     owner_q, owner_d, sel;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               init_q;
  logic               active;
  logic               lsu_req, shru_req, sel_req, gnt;
  logic               lsu_grant, shru_grant, burst_full;

  // Selection, output steering and next-state logic.
  // The arbiter is held quiet (no selection, all outputs zero) while reset
  // is asserted and for the first cycle after it; init_q marks the end of
  // that window. A grant only counts when the selected requester is still
  // requesting, so a stale gnt cannot leak to either side.
  always_comb begin
    active     = rst_ni & init_q;
    lsu_req    = lsu_req_i.data_req;
    shru_req   = shru_req_i.data_req;
    gnt        = dcache_rsp_i.data_gnt;
    burst_full = (burst_q == BURST_MAX);

    sel = OWN_NONE;
    if (!active) begin
      sel = OWN_NONE;
    end else if (owner_q != OWN_NONE) begin
      sel = owner_q;
    end else if (shru_req && !(lsu_req && burst_full)) begin
      sel = OWN_SHRU;
    end else if (lsu_req) begin
      sel = OWN_LSU;
    end

    sel_req    = ((sel == OWN_LSU) && lsu_req) || ((sel == OWN_SHRU) && shru_req);
    lsu_grant  = (sel == OWN_LSU)  && lsu_req  && gnt;
    shru_grant = (sel == OWN_SHRU) && shru_req && gnt;

    // The whole struct of the selected side is forwarded, including
    // kill_req, so a kill is only seen from the requester that owns the port.
    dcache_req_o = '0;
    case (sel)
      OWN_LSU:  dcache_req_o = lsu_req_i;
      OWN_SHRU: dcache_req_o = shru_req_i;
      default:  dcache_req_o = '0;
    endcase

    // Read data belongs to the LSU regardless of who holds the port;
    // the SHRU only ever writes, so it gets grants and nothing else.
    lsu_rsp_o  = '0;
    shru_rsp_o = '0;
    if (active) begin
      lsu_rsp_o.data_rvalid = dcache_rsp_i.data_rvalid;
      lsu_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
    end
    lsu_rsp_o.data_gnt  = lsu_grant;
    shru_rsp_o.data_gnt = shru_grant;

    shru_owner_o  = (sel == OWN_SHRU);
    lsu_starved_o = active && lsu_req && burst_full;

    // Ownership sticks only while the selected requester waits for gnt;
    // a grant or a withdrawn request both release the port.
    owner_d = OWN_NONE;
    if (sel_req && !gnt) begin
      owner_d = sel;
    end

    // The counter tracks SHRU grants that overtook a waiting LSU. Any
    // cycle without an LSU request, or an LSU grant, resets it, and the
    // reset takes precedence over a simultaneous increment.
    burst_d = burst_q;
    if (shru_grant && lsu_req && !burst_full) begin
      burst_d = burst_q + 1'b1;
    end
    if (lsu_grant || !lsu_req) begin
      burst_d = '0;
    end
  end

  // State register. Reset drops any pending ownership so a requester that
  // was mid-handshake must re-issue its request afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= OWN_NONE;
      burst_q <= '0;
      init_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      init_q  <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // A requester left waiting without a grant must own the port next cycle.
  a_sticky_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (active && sel_req && !gnt) |=> (owner_q == $past(sel)));

  // Grants are only ever routed to the selected requester.
  a_lsu_gnt_selected : assert property (@(posedge clk_i)
    !(lsu_rsp_o.data_gnt && (sel != OWN_LSU)));
  a_shru_gnt_selected : assert property (@(posedge clk_i)
    !(shru_rsp_o.data_gnt && (sel != OWN_SHRU)));

  // The burst counter saturates and never runs past its limit.
  a_burst_bound : assert property (@(posedge clk_i)
    burst_q <= BURST_MAX);
`endif

endmodule

// File: tb/tb_shadow_dcache_port_arbiter.sv
// Scoreboard testbench for shadow_dcache_port_arbiter.
//
// The stimulus process drives one directed vector per clock and pushes the
// hand-computed expected outputs for that cycle into a queue. A separate
// monitor samples the DUT on the falling edge, pops one expectation and
// compares it against what the DUT presents.
module tb_shadow_dcache_port_arbiter;
  import shadow_dcache_port_arbiter_pkg::*;

  typedef struct packed {
    dcache_store_req_t dreq;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [XLEN-1:0]   lsu_rdata;
    logic              shru_gnt;
    logic              shru_rvalid;
    logic              shru_owner;
    logic              lsu_starved;
  } exp_t;

  logic              clk;
  logic              rst_n;
  dcache_store_req_t lsu_req;
  dcache_store_rsp_t lsu_rsp;
  dcache_store_req_t shru_req;
  dcache_store_rsp_t shru_rsp;
  dcache_store_req_t dcache_req;
  dcache_store_rsp_t dcache_rsp;
  logic              shru_owner;
  logic              lsu_starved;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors_applied = 0;
  int    miscompares     = 0;

  dcache_store_req_t zero_req;
  dcache_store_req_t lsu_a;
  dcache_store_req_t lsu_kill;
  dcache_store_req_t shru_s;

  shadow_dcache_port_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .lsu_req_i     (lsu_req),
    .lsu_rsp_o     (lsu_rsp),
    .shru_req_i    (shru_req),
    .shru_rsp_o    (shru_rsp),
    .dcache_req_o  (dcache_req),
    .dcache_rsp_i  (dcache_rsp),
    .shru_owner_o  (shru_owner),
    .lsu_starved_o (lsu_starved)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds an expected record; the SHRU never sees read data.
  function automatic exp_t mk(input dcache_store_req_t d, input logic lg, input logic sg,
                              input logic so, input logic ls, input logic rv,
                              input logic [XLEN-1:0] rd);
    exp_t e;
    e.dreq        = d;
    e.lsu_gnt     = lg;
    e.lsu_rvalid  = rv;
    e.lsu_rdata   = rd;
    e.shru_gnt    = sg;
    e.shru_rvalid = 1'b0;
    e.shru_owner  = so;
    e.lsu_starved = ls;
    return e;
  endfunction

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected for that same cycle.
  task automatic applyStimulus(input string name, input logic rst,
                               input dcache_store_req_t l, input dcache_store_req_t s,
                               input logic g, input logic rv, input logic [XLEN-1:0] rd,
                               input exp_t e);
    @(posedge clk);
    #1;
    rst_n                  = rst;
    lsu_req                = l;
    shru_req               = s;
    dcache_rsp.data_gnt    = g;
    dcache_rsp.data_rvalid = rv;
    dcache_rsp.data_rdata  = rd;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Compares the DUT outputs against one expected record.
  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act.dreq        = dcache_req;
    act.lsu_gnt     = lsu_rsp.data_gnt;
    act.lsu_rvalid  = lsu_rsp.data_rvalid;
    act.lsu_rdata   = lsu_rsp.data_rdata;
    act.shru_gnt    = shru_rsp.data_gnt;
    act.shru_rvalid = shru_rsp.data_rvalid;
    act.shru_owner  = shru_owner;
    act.lsu_starved = lsu_starved;
    vectors_applied++;
    if (act !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  // Monitor: one comparison per falling edge whenever an expectation is pending.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, e);
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    zero_req = '0;
    lsu_a    = '{address_index: 12'h010, address_tag: 20'hAAAAA, data_wdata: 32'h1111_1111,
                 data_req: 1'b1, data_we: 1'b1, data_be: 4'hF, data_size: 2'd2,
                 kill_req: 1'b0, tag_valid: 1'b1};
    lsu_kill = lsu_a;
    lsu_kill.data_req = 1'b0;
    lsu_kill.kill_req = 1'b1;
    shru_s   = '{address_index: 12'h3C4, address_tag: 20'h55555, data_wdata: 32'hCAFE_F00D,
                 data_req: 1'b1, data_we: 1'b1, data_be: 4'hF, data_size: 2'd2,
                 kill_req: 1'b0, tag_valid: 1'b1};

    rst_n      = 1'b0;
    lsu_req    = '0;
    shru_req   = '0;
    dcache_rsp = '0;

    // Reset and the first cycle after it keep every output at zero.
    applyStimulus("rst_hold", 1'b0, lsu_a, shru_s, 1'b1, 1'b1, 32'h5, mk(zero_req, 0, 0, 0, 0, 0, 0));
    applyStimulus("rst_first", 1'b1, lsu_a, shru_s, 1'b1, 1'b1, 32'h5, mk(zero_req, 0, 0, 0, 0, 0, 0));

    // LSU alone, granted immediately.
    applyStimulus("lsu_only", 1'b1, lsu_a, zero_req, 1'b1, 1'b0, 0, mk(lsu_a, 1, 0, 0, 0, 0, 0));

    // Both request; SHRU owns while gnt is held low, granted on the fourth cycle.
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("both_wait%0d", i), 1'b1, lsu_a, shru_s, 1'b0, 1'b0, 0,
                    mk(shru_s, 0, 0, 1, 0, 0, 0));
    applyStimulus("both_shru_gnt", 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0, mk(shru_s, 0, 1, 1, 0, 0, 0));
    applyStimulus("after_shru_gnt", 1'b1, lsu_a, zero_req, 1'b1, 1'b0, 0, mk(lsu_a, 1, 0, 0, 0, 0, 0));

    // LSU owns first, so a later SHRU request must wait behind it.
    applyStimulus("lsu_take", 1'b1, lsu_a, zero_req, 1'b0, 1'b0, 0, mk(lsu_a, 0, 0, 0, 0, 0, 0));
    applyStimulus("lsu_sticky", 1'b1, lsu_a, shru_s, 1'b0, 1'b0, 0, mk(lsu_a, 0, 0, 0, 0, 0, 0));
    applyStimulus("lsu_sticky_gnt", 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0, mk(lsu_a, 1, 0, 0, 0, 0, 0));

    // LSU owns, then kills its request; the kill is forwarded and SHRU follows.
    applyStimulus("kill_own", 1'b1, lsu_a, zero_req, 1'b0, 1'b0, 0, mk(lsu_a, 0, 0, 0, 0, 0, 0));
    applyStimulus("kill_drop", 1'b1, lsu_kill, shru_s, 1'b0, 1'b0, 0, mk(lsu_kill, 0, 0, 0, 0, 0, 0));
    applyStimulus("kill_shru_sel", 1'b1, zero_req, shru_s, 1'b0, 1'b0, 0, mk(shru_s, 0, 0, 1, 0, 0, 0));
    applyStimulus("kill_shru_gnt", 1'b1, zero_req, shru_s, 1'b1, 1'b0, 0, mk(shru_s, 0, 1, 1, 0, 0, 0));

    // 16 SHRU saves against a waiting LSU: every fifth grant goes to the LSU.
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4)
        applyStimulus($sformatf("stream%0d_L", i), 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0,
                      mk(lsu_a, 1, 0, 0, 1, 0, 0));
      else
        applyStimulus($sformatf("stream%0d_S", i), 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0,
                      mk(shru_s, 0, 1, 1, 0, 0, 0));
    end

    // Two overtaking grants, then a cycle with no LSU request clears the
    // count, so four more SHRU grants are allowed before the LSU wins.
    for (int i = 0; i < 2; i++)
      applyStimulus($sformatf("clr_pre%0d", i), 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0,
                    mk(shru_s, 0, 1, 1, 0, 0, 0));
    applyStimulus("clr_gap", 1'b1, zero_req, shru_s, 1'b1, 1'b0, 0, mk(shru_s, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("clr_post%0d", i), 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0,
                    mk(shru_s, 0, 1, 1, 0, 0, 0));
    applyStimulus("clr_lsu", 1'b1, lsu_a, shru_s, 1'b1, 1'b0, 0, mk(lsu_a, 1, 0, 0, 1, 0, 0));

    // Read data goes to the LSU even while the SHRU holds the port.
    applyStimulus("rvalid_lsu", 1'b1, zero_req, shru_s, 1'b0, 1'b1, 32'hDEAD_BEEF,
                  mk(shru_s, 0, 0, 1, 0, 1, 32'hDEAD_BEEF));
    applyStimulus("rvalid_gnt", 1'b1, zero_req, shru_s, 1'b1, 1'b0, 0, mk(shru_s, 0, 1, 1, 0, 0, 0));

    // Reset while SHRU waits for gnt: ownership dropped, no stale grant.
    applyStimulus("mid_own", 1'b1, zero_req, shru_s, 1'b0, 1'b0, 0, mk(shru_s, 0, 0, 1, 0, 0, 0));
    applyStimulus("mid_rst", 1'b0, zero_req, shru_s, 1'b1, 1'b0, 0, mk(zero_req, 0, 0, 0, 0, 0, 0));
    applyStimulus("mid_first", 1'b1, zero_req, zero_req, 1'b1, 1'b0, 0, mk(zero_req, 0, 0, 0, 0, 0, 0));
    applyStimulus("mid_idle", 1'b1, zero_req, zero_req, 1'b0, 1'b0, 0, mk(zero_req, 0, 0, 0, 0, 0, 0));
    applyStimulus("mid_lsu", 1'b1, lsu_a, zero_req, 1'b0, 1'b0, 0, mk(lsu_a, 0, 0, 0, 0, 0, 0));
    applyStimulus("mid_lsu_gnt", 1'b1, lsu_a, zero_req, 1'b1, 1'b0, 0, mk(lsu_a, 1, 0, 0, 0, 0, 0));

    // Give the monitor a bounded window to drain the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
